dac_spi_tx: RTL and testbench
=============================

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 SHALL have parameter N, default 25, the filter output word width in bits (signed two's complement).
REQ-002 SHALL have parameter FRAC, default 16, the number of fractional bits in Yk.
REQ-003 SHALL have parameter CLK_DIV, default 4, the clk cycles per SCLK half-period (legal range ≥1).
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port Yk, input, N bits: filter output sample.
REQ-007 SHALL have port Finish, input, 1 bit: one-cycle pulse marking Yk valid.
REQ-008 SHALL have port SCLK, output, 1 bit: DAC serial clock, idle high.
REQ-009 SHALL have port SYNC, output, 1 bit: DAC frame select, active low.
REQ-010 SHALL have port SDATA, output, 1 bit: serial data, MSB first.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-013 SHALL have port overrun, output, 1 bit: one-cycle pulse when a Finish is dropped.

Function
REQ-014 SHALL, in IDLE with Finish=1, capture Yk into an internal sample register and go to LOAD on the next edge.
REQ-015 SHALL, in LOAD, compute S = Yk arithmetic-shifted right by (FRAC-11), saturate S to [-2048, 2047], and form code = S + 2048 (12 bits, offset binary); code SHALL be registered in one cycle.
REQ-016 SHALL build a 16-bit frame {4'b0000, code[11:0]} and enter SHIFT one cycle after LOAD.
REQ-017 SHALL drive SYNC low for the whole SHIFT state: exactly 16 SCLK periods, each 2*CLK_DIV clk cycles.
REQ-018 SHALL drive SCLK low for the first CLK_DIV cycles of each bit period and high for the second CLK_DIV cycles.
REQ-019 SHALL update SDATA at the start of each bit period (SCLK falling edge); the DAC samples on SCLK rising edge.
REQ-020 SHALL, after bit 0, go to GAP, hold SYNC high and SCLK high for 2*CLK_DIV cycles, pulse done in the last GAP cycle, then return to IDLE.
REQ-021 SHALL ignore Finish in every state except IDLE; in those states Finish SHALL pulse overrun in the following cycle and leave the frame unchanged.
REQ-022 SHALL hold SDATA at 0 outside SHIFT.
REQ-023 SHALL, when Finish arrives in the same cycle that done pulses, not accept it (the state is still GAP) and SHALL raise overrun.
REQ-024 SHALL have a latency from the Finish edge to SYNC falling of 2 clk cycles; total busy time SHALL be 2 + 34*CLK_DIV cycles.

Reset
REQ-025 SHALL, while rst_n=0 at a clk edge, force state IDLE, SCLK=1, SYNC=1, SDATA=0, busy=0, done=0, overrun=0, and clear the sample, code, shift and counter registers.
REQ-026 SHALL, on a reset mid-frame, abort the frame on the next edge with no done pulse; a partial frame is acceptable because the DAC discards frames with an early SYNC rise.

Structure
REQ-027 SHALL take FRAME_BITS=16, DAC_BITS=12, the control prefix 4'b0000 and the state encoding (IDLE, LOAD, SHIFT, GAP) from a shared package.
REQ-028 SHALL implement the shift/saturate/offset step as sub-module sat_dac_code, combinational and parameterised on N and FRAC, registered by the parent.
REQ-029 SHALL use one bit counter (0..15) and one divider counter (0..CLK_DIV-1); no other clocks are generated.

Verification
REQ-030 SHALL cover Yk=25'h0000000 with Finish -> frame 16'h0800 on SDATA, 16 SCLK periods, done once.
REQ-031 SHALL cover Yk=25'h0000040 -> frame 16'h0802; Yk=25'h0010000 (+1.0) -> frame 16'h0FFF (saturated).
REQ-032 SHALL cover Yk=25'h1FF0000 (-1.0) -> frame 16'h0000; Yk=25'h1000000 (most negative) -> frame 16'h0000.
REQ-033 SHALL cover Finish pulses at SHIFT bit 5 and in the done cycle -> overrun pulses twice, original frame bits unchanged, no extra frame.
REQ-034 SHALL cover rst_n low for one cycle at SHIFT bit 8 -> next edge SYNC=1, SCLK=1, busy=0, no done; the next Finish produces a full correct frame.
REQ-035 SHALL cover CLK_DIV=1 and CLK_DIV=4 -> SCLK period 2 and 8 clk cycles, busy length 36 and 138 cycles.

Source files
------------

// File: rtl/dac_spi_tx_pkg.sv
// dac_spi_tx_pkg: frame geometry, control prefix and FSM states shared by the DAC SPI transmitter
package dac_spi_tx_pkg;
  localparam int FRAME_BITS = 16;
  localparam int DAC_BITS = 12;
  localparam logic [3:0] CTRL_PREFIX = 4'b0000;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
endpackage

// File: rtl/dac_spi_tx_sat.sv
// sat_dac_code: scale a signed fixed-point sample (yk) to a saturated 12-bit offset-binary DAC code (code)
module sat_dac_code
  import dac_spi_tx_pkg::*;
#(
  parameter int N = 25,
  parameter int FRAC = 16
) (
  input  logic [N-1:0]        yk,
  output logic [DAC_BITS-1:0] code
);
  localparam int SH = FRAC - (DAC_BITS - 1);
  localparam logic signed [N-1:0] MAXV = N'(2 ** (DAC_BITS - 1) - 1);
  localparam logic signed [N-1:0] MINV = N'(-(2 ** (DAC_BITS - 1)));
  logic signed [N-1:0] s;
  assign s = $signed(yk) >>> SH;
  assign code = s > MAXV ? '1 : s < MINV ? '0 : {~s[DAC_BITS-1], s[DAC_BITS-2:0]};
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialise each Finish-qualified Yk as a 16-bit DAC frame on SCLK/SYNC/SDATA with busy/done/overrun status
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int N = 25,
  parameter int FRAC = 16,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] Yk,
  input  logic         Finish,
  output logic         SCLK,
  output logic         SYNC,
  output logic         SDATA,
  output logic         busy,
  output logic         done,
  output logic         overrun
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PEN = DW'(CLK_DIV > 1 ? CLK_DIV - 2 : 0);
  state_t state;
  logic [N-1:0] sample;
  logic [DAC_BITS-1:0] code, code_c;
  logic [FRAME_BITS-1:0] shreg, frame;
  logic [3:0] bit_cnt;
  logic [DW-1:0] div;
  logic code_ok, div_end, gap_pen;
  sat_dac_code #(.N(N), .FRAC(FRAC)) u_sat (.yk(sample), .code(code_c));
  assign frame = {CTRL_PREFIX, code};
  assign div_end = div == DIV_LAST;
  assign gap_pen = CLK_DIV == 1 ? !bit_cnt[0] : bit_cnt[0] && div == DIV_PEN;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      SCLK <= 1'b1;
      SYNC <= 1'b1;
      SDATA <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
      sample <= '0;
      code <= '0;
      code_ok <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      div <= '0;
    end else begin
      overrun <= Finish && state != IDLE;
      done <= 1'b0;
      case (state)
        IDLE: if (Finish) begin
          sample <= Yk;
          code_ok <= 1'b0;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: if (!code_ok) begin
          code <= code_c;
          code_ok <= 1'b1;
        end else begin
          SDATA <= frame[FRAME_BITS-1];
          shreg <= frame << 1;
          SYNC <= 1'b0;
          SCLK <= 1'b0;
          div <= '0;
          bit_cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: if (!div_end) div <= div + 1'b1;
        else begin
          div <= '0;
          if (!SCLK) SCLK <= 1'b1;
          else if (bit_cnt == 4'(FRAME_BITS - 1)) begin
            SYNC <= 1'b1;
            SDATA <= 1'b0;
            bit_cnt <= '0;
            state <= GAP;
          end else begin
            SCLK <= 1'b0;
            SDATA <= shreg[FRAME_BITS-1];
            shreg <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        GAP: begin
          done <= gap_pen;
          if (!div_end) div <= div + 1'b1;
          else begin
            div <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt[0]) begin
              bit_cnt <= '0;
              busy <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: randomized scoreboard bench for dac_spi_tx at CLK_DIV=4 and CLK_DIV=1
module tb_dac_spi_tx;
  localparam int FRAC = 16;
  typedef struct {int d; logic [15:0] f;} exp_t;
  logic clk = 0;
  logic rstn [2];
  logic fin [2];
  logic [24:0] yk [2];
  logic sclk [2], sync [2], sdata [2], busy [2], done [2], ovr [2];
  exp_t q[$];
  int tests = 0, fails = 0;
  int ndone [2] = '{0, 0}, novr [2] = '{0, 0}, frames_exp [2] = '{0, 0}, ovr_exp [2] = '{0, 0};
  bit abort_ok [2] = '{0, 0};
  bit mon_en = 0;
  always #5 clk = ~clk;
  dac_spi_tx #(.N(25), .FRAC(16), .CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rstn[0]), .Yk(yk[0]), .Finish(fin[0]),
    .SCLK(sclk[0]), .SYNC(sync[0]), .SDATA(sdata[0]), .busy(busy[0]), .done(done[0]), .overrun(ovr[0]));
  dac_spi_tx #(.N(25), .FRAC(16), .CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rstn[1]), .Yk(yk[1]), .Finish(fin[1]),
    .SCLK(sclk[1]), .SYNC(sync[1]), .SDATA(sdata[1]), .busy(busy[1]), .done(done[1]), .overrun(ovr[1]));
  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] ref_frame(logic [24:0] y);
    int v, s;
    v = y[24] ? int'(y) - (1 << 25) : int'(y);
    s = v / (2 ** (FRAC - 11));
    if (v < 0 && v % (2 ** (FRAC - 11)) != 0) s--;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    return 16'(s + 2048);
  endfunction
  function automatic logic [24:0] rnd_y();
    int m;
    m = $urandom_range(0, 2);
    if (m == 0) return 25'($urandom);
    if (m == 1) return 25'(int'($urandom_range(0, 140000)) - 70000);
    return 25'(int'($urandom_range(0, 4000)) - 2000);
  endfunction
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int CD = g == 0 ? 4 : 1;
    int cyc = 0, nr = 0, fall = 0, lr = 0, brise = 0;
    logic [15:0] sh = '0;
    bit psync = 1, psclk = 1, pbusy = 0, fr_ok = 0, ab = 0;
    exp_t e;
    always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
        if (!pbusy && busy[g]) brise = cyc;
        if (psync && !sync[g]) begin
          nr = 0;
          fall = cyc;
          chk("sync_latency", cyc - brise, 2);
        end
        if (!sync[g] && !psclk && sclk[g]) begin
          sh = {sh[14:0], sdata[g]};
          chk(nr == 0 ? "first_rise" : "sclk_period", cyc - (nr == 0 ? fall : lr), nr == 0 ? CD : 2 * CD);
          lr = cyc;
          nr++;
        end
        if (!psync && sync[g]) begin
          if (nr == 16) begin
            if (q.size() == 0) chk("unexpected_frame", int'(sh), -1);
            else begin
              e = q.pop_front();
              chk("frame_dut", g, e.d);
              chk("frame", int'(sh), int'(e.f));
            end
            fr_ok = 1;
          end else if (abort_ok[g]) begin
            abort_ok[g] = 0;
            ab = 1;
            if (q.size() > 0) void'(q.pop_front());
          end else chk("frame_bits", nr, 16);
        end
        if (sync[g]) chk("idle_lines", {sclk[g], sdata[g]}, 2);
        if (done[g]) begin
          chk("done_after_frame", fr_ok, 1);
          fr_ok = 0;
          ndone[g]++;
        end
        if (ovr[g]) novr[g]++;
        if (pbusy && !busy[g]) begin
          if (!ab) chk("busy_len", cyc - brise, 2 + 34 * CD);
          ab = 0;
        end
      end
      psync = sync[g];
      psclk = sclk[g];
      pbusy = busy[g];
    end
  end
  task automatic run_frame(int d, logic [24:0] y, logic [15:0] ef, bit i5, bit idn, int rst_bit);
    int cd, l;
    cd = d == 0 ? 4 : 1;
    l = 2 + 34 * cd;
    @(negedge clk);
    fin[d] = 1;
    yk[d] = y;
    q.push_back('{d, ef});
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      fin[d] = 0;
      yk[d] = 25'($urandom);
      if (i5 && k == 3 + 10 * cd) begin fin[d] = 1; ovr_exp[d]++; end
      if (idn && k == l) begin fin[d] = 1; ovr_exp[d]++; end
      if (rst_bit >= 0 && k == 3 + 2 * cd * rst_bit) begin
        abort_ok[d] = 1;
        rstn[d] = 0;
        @(negedge clk);
        chk("abort_sync", sync[d], 1);
        chk("abort_sclk", sclk[d], 1);
        chk("abort_busy", busy[d], 0);
        chk("abort_done", done[d], 0);
        rstn[d] = 1;
        break;
      end
    end
    if (rst_bit < 0) frames_exp[d]++;
  endtask
  task automatic rnd_frame(int d);
    logic [24:0] y;
    y = rnd_y();
    run_frame(d, y, ref_frame(y), 0, 0, -1);
    repeat ($urandom_range(0, 3)) begin @(negedge clk); fin[d] = 0; end
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin rstn[d] = 0; fin[d] = 0; yk[d] = '0; end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_sync", sync[d], 1);
      chk("rst_sclk", sclk[d], 1);
      chk("rst_sdata", sdata[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_done", done[d], 0);
      chk("rst_overrun", ovr[d], 0);
      rstn[d] = 1;
    end
    mon_en = 1;
    run_frame(0, 25'h0000000, 16'h0800, 0, 0, -1);
    run_frame(0, 25'h0000040, 16'h0802, 0, 0, -1);
    run_frame(0, 25'h0010000, 16'h0FFF, 0, 0, -1);
    run_frame(0, 25'h1FF0000, 16'h0000, 0, 0, -1);
    run_frame(0, 25'h1000000, 16'h0000, 0, 1, -1);
    run_frame(0, 25'h0000040, 16'h0802, 1, 1, -1);
    run_frame(0, 25'h0001234, ref_frame(25'h0001234), 0, 0, 8);
    run_frame(0, 25'h0000000, 16'h0800, 0, 0, -1);
    for (int i = 0; i < 10; i++) rnd_frame(0);
    @(negedge clk);
    fin[0] = 0;
    repeat (5) @(negedge clk);
    run_frame(1, 25'h0000000, 16'h0800, 0, 0, -1);
    run_frame(1, 25'h0010000, 16'h0FFF, 1, 1, -1);
    run_frame(1, 25'h1FF0000, 16'h0000, 0, 0, 8);
    run_frame(1, 25'h0000040, 16'h0802, 0, 0, -1);
    for (int i = 0; i < 10; i++) rnd_frame(1);
    @(negedge clk);
    fin[1] = 0;
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("done_count", ndone[d], frames_exp[d]);
      chk("overrun_count", novr[d], ovr_exp[d]);
    end
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
